logic_unit_arbiter: RTL
=======================

# logic_unit_arbiter

Shares a single 32-bit bitwise logic unit (AND/OR/XOR/NOR) between two requesters with valid/ready handshakes, round-robin arbitration and a registered result. Sits beside the ALU in the MIPS datapath so that the main execute path and an auxiliary client (debug/test port or a second issue slot) can time-share one logic unit. At most one transaction is in flight; each result returns to the requester that issued it.

## Interface
Parameters:
- WIDTH, 32, operand/result width; only 32 is supported.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  2  per-requester request valid; bit i belongs to requester i.
- req_ready  out  2  per-requester accept; at most one bit is set per cycle.
- req_op0, req_op1  in  2 each  operation: 00 AND, 01 OR, 10 XOR, 11 NOR.
- req_a0, req_b0, req_a1, req_b1  in  32 each  operands.
- rsp_valid  out  2  result valid for requester i.
- rsp_ready  in  2  requester i accepts its result.
- rsp_data  out  32  result, shared by both requesters and meaningful only where rsp_valid is set.
- rsp_zero  out  1  high when rsp_data == 0.
- busy  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any req_valid bit is set, grant one requester and assert its req_ready combinationally in the same cycle.
  - On that edge, latch the op, A, B and the grant id (gid); go to EXEC.
  - If no request is valid, stay in IDLE.
- Arbitration:
  - Round-robin pointer `last`, reset value 1, so requester 0 wins first.
  - A lone valid request is always granted.
  - When both are valid, grant the requester other than `last`.
  - `last` updates to gid on each grant.
- EXEC:
  - The combinational logic unit computes on the latched operands.
  - Result and zero flag are registered; go to RESP.
- RESP:
  - Assert rsp_valid[gid] only.
  - Hold rsp_data and rsp_zero stable until rsp_ready[gid] is high.
  - On that edge, return to IDLE.
  - rsp_ready on the non-granted requester is ignored.
- req_ready is 0 in EXEC and RESP. Requests arriving then are not dropped: the requester holds req_valid until it is granted.
- Operand and op changes while req_valid is high but before grant have no effect; only values present on the grant edge matter.
- reset, including mid-transaction:
  - State returns to IDLE and `last` to 1.
  - Outputs: req_ready 0 during the reset cycle, rsp_valid 0, rsp_data 0, rsp_zero 1, busy 0.
  - The in-flight transaction is discarded with no response.
- Widths: no carries or overflow. NOR is the bitwise ~(A|B) over all 32 bits.

## Timing
- Accept at edge N (req_valid & req_ready), result registered at N+1, rsp_valid high from cycle N+2.
- Minimum accept-to-response latency is 2 cycles.
- Minimum issue interval is 3 cycles when rsp_ready is already high in RESP.
- No back-to-back acceptance: the first cycle after the RESP handshake is IDLE, and a new grant can occur in that cycle.
- req_ready depends combinationally on req_valid and `last` only; there is no path from rsp_ready to req_ready.

## Structure
- Shared package (logic_pkg, include file):
  - op encodings LOP_AND, LOP_OR, LOP_XOR, LOP_NOR;
  - state encodings S_IDLE, S_EXEC, S_RESP;
  - WIDTH constant.
- Sub-module logic_unit_32b: purely combinational. Ports O, A, B, op; it instantiates the team's 32-bit gate modules and selects the result with a 4:1 mux on op.
- The arbiter holds the FSM, the round-robin pointer, the operand/op/gid registers and the result register.

## Test plan
- Single request, requester 0:
  - Stimulus: op NOR, A=0x0000_0000, B=0x0000_0000.
  - Response: rsp_valid[0] at accept+2, rsp_data=0xFFFF_FFFF, rsp_zero=0.
- Both requesters held valid for 4 transactions:
  - Stimulus: requester 0 AND 0xF0F0_F0F0/0xFF00_FF00; requester 1 XOR 0xAAAA_AAAA/0xAAAA_AAAA.
  - Response: grants alternate 0,1,0,1; results 0xF000_F000 (zero=0) and 0x0000_0000 (zero=1) on the matching rsp_valid bit.
- Response backpressure:
  - Stimulus: hold rsp_ready[gid]=0 for 5 cycles.
  - Response: rsp_valid and rsp_data stable, busy=1, req_ready=00 throughout; release, then the next grant occurs 1 cycle later.
- Wrong-owner ready:
  - Stimulus: gid=1 in RESP, assert rsp_ready[0] only.
  - Response: no state change; rsp_valid stays 2'b10.
- Reset in EXEC:
  - Stimulus: assert reset for 1 cycle.
  - Response: next cycle IDLE, rsp_valid=00, rsp_data=0, rsp_zero=1, busy=0; a subsequent simultaneous request grants requester 0.
- All 4 ops exhaustive: random A/B checked against a reference model, 1000 transactions each, with no lost or duplicated responses.

Source files
------------

// File: rtl/logic_pkg.sv
// Shared definitions for the time-shared 32-bit logic unit: operation codes,
// arbiter FSM state encodings, datapath width and a small grant helper.
package logic_pkg;

    // Datapath width; the logic unit and its gate modules are built for 32 bits.
    localparam int WIDTH = 32;

    // Operation encodings presented on req_op0 / req_op1.
    typedef enum logic [1:0] {
        LOP_AND = 2'b00,
        LOP_OR  = 2'b01,
        LOP_XOR = 2'b10,
        LOP_NOR = 2'b11
    } lop_t;

    // Arbiter FSM states. This encoding is also what dbg_state shows.
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_RESP = 2'b10
    } state_t;

    // Converts a requester id into its one-hot per-requester bit position.
    function automatic logic [1:0] id_to_onehot(input logic id);
        return id ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/gate_32b.sv
// 32-bit bitwise gate. One module covers the four gate kinds; FUNC picks
// which gate a given instance is, so every instance is a plain array of gates.
module gate_32b
    import logic_pkg::*;
#(
    parameter lop_t FUNC = LOP_AND
) (
    output logic [WIDTH-1:0] O,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B
);

    if (FUNC == LOP_AND) begin : g_and
        assign O = A & B;
    end else if (FUNC == LOP_OR) begin : g_or
        assign O = A | B;
    end else if (FUNC == LOP_XOR) begin : g_xor
        assign O = A ^ B;
    end else begin : g_nor
        assign O = ~(A | B);
    end

endmodule

// File: rtl/logic_unit_32b.sv
// Purely combinational 32-bit logic unit. All four gates evaluate in
// parallel and a 4:1 mux on op selects the result. No carries, no state.
module logic_unit_32b
    import logic_pkg::*;
(
    output logic [WIDTH-1:0] O,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  lop_t             op
);

    logic [WIDTH-1:0] and_o;
    logic [WIDTH-1:0] or_o;
    logic [WIDTH-1:0] xor_o;
    logic [WIDTH-1:0] nor_o;

    gate_32b #(.FUNC(LOP_AND)) u_and (.O(and_o), .A(A), .B(B));
    gate_32b #(.FUNC(LOP_OR))  u_or  (.O(or_o),  .A(A), .B(B));
    gate_32b #(.FUNC(LOP_XOR)) u_xor (.O(xor_o), .A(A), .B(B));
    gate_32b #(.FUNC(LOP_NOR)) u_nor (.O(nor_o), .A(A), .B(B));

    // Result mux: pick the gate output named by op.
    always_comb begin
        O = and_o;
        case (op)
            LOP_AND: O = and_o;
            LOP_OR:  O = or_o;
            LOP_XOR: O = xor_o;
            LOP_NOR: O = nor_o;
            default: O = and_o;
        endcase
    end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Two-requester front end for one shared logic unit.
//
// Handshakes: a request transfers on a rising edge where req_valid[i] and
// req_ready[i] are both high; a response transfers on a rising edge where
// rsp_valid[i] and rsp_ready[i] are both high. A requester keeps req_valid
// (with stable or changing operands) until it sees req_ready; only the
// operands present on the transfer edge are used. rsp_data/rsp_zero are held
// stable for as long as rsp_valid is up.
//
// Flow: IDLE grants one requester (round robin on contention) and captures
// its op/operands, EXEC registers the logic-unit result, RESP presents it to
// the owning requester until it accepts. Only one transaction is in flight.
module logic_unit_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [1:0]       req_op0,
    input  logic [1:0]       req_op1,
    input  logic [WIDTH-1:0] req_a0,
    input  logic [WIDTH-1:0] req_b0,
    input  logic [WIDTH-1:0] req_a1,
    input  logic [WIDTH-1:0] req_b1,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_zero,
    output logic             busy,
    output logic [1:0]       dbg_state
);

    import logic_pkg::lop_t;
    import logic_pkg::LOP_AND;
    import logic_pkg::state_t;
    import logic_pkg::S_IDLE;
    import logic_pkg::S_EXEC;
    import logic_pkg::S_RESP;
    import logic_pkg::id_to_onehot;

    state_t           state;
    state_t           state_nx;

    // Round-robin pointer: id of the most recent grant. Resets to 1 so that
    // requester 0 wins the first contended grant.
    logic             last;
    // Owner of the transaction currently in flight.
    logic             gid;

    lop_t             op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;

    logic             grant_any;
    logic             grant_id;
    logic             accept;
    lop_t             sel_op;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [WIDTH-1:0] lu_out;

    // Arbitration: a lone request always wins; on contention the requester
    // that was not granted last time wins. Depends only on req_valid and last.
    always_comb begin
        grant_any = |req_valid;
        grant_id  = 1'b0;
        if (req_valid == 2'b11) begin
            grant_id = ~last;
        end else if (req_valid[1]) begin
            grant_id = 1'b1;
        end
    end

    // Operand steering: present the winning requester's op and operands.
    always_comb begin
        sel_op = grant_id ? lop_t'(req_op1) : lop_t'(req_op0);
        sel_a  = grant_id ? req_a1 : req_a0;
        sel_b  = grant_id ? req_b1 : req_b0;
    end

    // FSM next state and handshake outputs. req_ready is suppressed during
    // reset so nothing is accepted on a reset edge.
    always_comb begin
        state_nx  = state;
        req_ready = 2'b00;
        rsp_valid = 2'b00;
        accept    = 1'b0;
        case (state)
            S_IDLE: begin
                if (grant_any && !reset) begin
                    req_ready = id_to_onehot(grant_id);
                    accept    = 1'b1;
                    state_nx  = S_EXEC;
                end
            end
            S_EXEC: begin
                state_nx = S_RESP;
            end
            S_RESP: begin
                rsp_valid = id_to_onehot(gid);
                // Only the owner's rsp_ready can complete the response.
                if (rsp_ready[gid]) begin
                    state_nx = S_IDLE;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Grant bookkeeping and operand capture on the accept edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            last <= 1'b1;
            gid  <= 1'b0;
            op_q <= LOP_AND;
            a_q  <= '0;
            b_q  <= '0;
        end else if (accept) begin
            last <= grant_id;
            gid  <= grant_id;
            op_q <= sel_op;
            a_q  <= sel_a;
            b_q  <= sel_b;
        end
    end

    logic_unit_32b u_lu (
        .O  (lu_out),
        .A  (a_q),
        .B  (b_q),
        .op (op_q)
    );

    // Result register: loaded once in EXEC, then held through RESP.
    always_ff @(posedge clk) begin
        if (reset) begin
            result_q <= '0;
            zero_q   <= 1'b1;
        end else if (state == S_EXEC) begin
            result_q <= lu_out;
            zero_q   <= (lu_out == '0);
        end
    end

    assign rsp_data  = result_q;
    assign rsp_zero  = zero_q;
    assign busy      = (state != S_IDLE);
    assign dbg_state = state;

endmodule
